// File: rtl/alu_ex_stage_if.sv
// Handshake and data bundle between ID/EX, the execute stage and MEM.
// The slave modport is the stage's view; the master modport is the upstream/downstream driver's view.
interface alu_ex_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    // ID/EX side
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        Operation;
    logic [DATA_W-1:0] SrcA;
    logic [DATA_W-1:0] SrcB;
    logic              Branch;
    logic              RegWrite_in;
    logic [REG_W-1:0]  rd_in;
    logic              flush;

    // EX/MEM side
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] ALUResult;
    logic              BrTaken;
    logic              RegWrite_out;
    logic [REG_W-1:0]  rd_out;

    modport slave (
        input  in_valid, Operation, SrcA, SrcB, Branch, RegWrite_in, rd_in, flush, out_ready,
        output in_ready, out_valid, ALUResult, BrTaken, RegWrite_out, rd_out
    );

    modport master (
        output in_valid, Operation, SrcA, SrcB, Branch, RegWrite_in, rd_in, flush, out_ready,
        input  in_ready, out_valid, ALUResult, BrTaken, RegWrite_out, rd_out
    );
endinterface

// File: rtl/alu_ex_stage.sv
// Execute stage: combinational ALU feeding a registered EX/MEM boundary
// with a 2-entry (main + skid) buffer so in_ready never depends combinationally on out_ready.
module alu_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic                clk,
    input  logic                reset,
    alu_ex_stage_if.slave       bus
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_EQ   = 4'b0101;
    localparam logic [3:0] OP_NE   = 4'b0110;
    localparam logic [3:0] OP_LT   = 4'b0111;
    localparam logic [3:0] OP_GE   = 4'b1000;
    localparam logic [3:0] OP_PASS = 4'b1100;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              branch;
        logic              regwrite;
        logic [REG_W-1:0]  rd;
    } payload_t;

    logic [DATA_W-1:0] alu_result;
    logic              signed_lt;
    payload_t          in_payload;

    payload_t          main_reg,  main_next;
    payload_t          skid_reg,  skid_next;
    logic              main_valid_reg, main_valid_next;
    logic              skid_valid_reg, skid_valid_next;

    logic              accept;
    logic              drain;

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    assign signed_lt = $signed(bus.SrcA) < $signed(bus.SrcB);

    always_comb begin
        alu_result = '0;
        case (bus.Operation)
            OP_AND:  alu_result = bus.SrcA & bus.SrcB;
            OP_OR:   alu_result = bus.SrcA | bus.SrcB;
            OP_XOR:  alu_result = bus.SrcA ^ bus.SrcB;
            OP_ADD:  alu_result = bus.SrcA + bus.SrcB;
            OP_SUB:  alu_result = bus.SrcA - bus.SrcB;
            OP_EQ:   alu_result = {{(DATA_W-1){1'b0}}, bus.SrcA == bus.SrcB};
            OP_NE:   alu_result = {{(DATA_W-1){1'b0}}, bus.SrcA != bus.SrcB};
            OP_LT:   alu_result = {{(DATA_W-1){1'b0}}, signed_lt};
            OP_GE:   alu_result = {{(DATA_W-1){1'b0}}, ~signed_lt};
            OP_PASS: alu_result = bus.SrcB;
            default: alu_result = '0;
        endcase
    end

    always_comb begin
        in_payload.result   = alu_result;
        in_payload.branch   = bus.Branch;
        in_payload.regwrite = bus.RegWrite_in;
        in_payload.rd       = bus.rd_in;
    end

    // ------------------------------------------------------------------
    // Skid buffer control
    // ------------------------------------------------------------------
    assign accept = bus.in_valid & ~skid_valid_reg;
    assign drain  = main_valid_reg & bus.out_ready;

    always_comb begin
        main_next       = main_reg;
        skid_next       = skid_reg;
        main_valid_next = main_valid_reg;
        skid_valid_next = skid_valid_reg;

        if (bus.flush) begin
            main_valid_next = 1'b0;
            skid_valid_next = 1'b0;
        end else if (skid_valid_reg) begin
            // in_ready is low here, so nothing new can arrive; only promote on drain.
            if (drain) begin
                main_next       = skid_reg;
                main_valid_next = 1'b1;
                skid_valid_next = 1'b0;
            end
        end else if (accept) begin
            if (!main_valid_reg || drain) begin
                main_next       = in_payload;
                main_valid_next = 1'b1;
            end else begin
                skid_next       = in_payload;
                skid_valid_next = 1'b1;
            end
        end else if (drain) begin
            main_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_reg       <= '0;
            skid_reg       <= '0;
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else begin
            main_reg       <= main_next;
            skid_reg       <= skid_next;
            main_valid_reg <= main_valid_next;
            skid_valid_reg <= skid_valid_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs; side effects are gated so stale data after flush is harmless
    // ------------------------------------------------------------------
    assign bus.in_ready     = ~skid_valid_reg;
    assign bus.out_valid    = main_valid_reg;
    assign bus.ALUResult    = main_reg.result;
    assign bus.BrTaken      = main_valid_reg & main_reg.branch & main_reg.result[0];
    assign bus.RegWrite_out = main_valid_reg & main_reg.regwrite;
    assign bus.rd_out       = main_reg.rd;

endmodule

// File: tb/tb_alu_ex_stage.sv
// Directed self-checking bench for alu_ex_stage: ALU ops, back-pressure, flush and async reset.
module tb_alu_ex_stage;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    alu_ex_stage_if #(.DATA_W(32), .REG_W(5)) ifc ();

    alu_ex_stage #(.DATA_W(32), .REG_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic br, input logic rw, input logic [4:0] rd);
        ifc.in_valid    = v;
        ifc.Operation   = op;
        ifc.SrcA        = a;
        ifc.SrcB        = b;
        ifc.Branch      = br;
        ifc.RegWrite_in = rw;
        ifc.rd_in       = rd;
    endtask

    // Offer one item with out_ready high, advance one edge and check it is on the outputs.
    task automatic send_check(input string tag, input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic br,
                              input logic [31:0] exp_res, input logic exp_br);
        drive(1'b1, op, a, b, br, 1'b1, 5'd9);
        step();
        $display("txn %s op=%b a=%h b=%h -> result=%h brtaken=%b", tag, op, a, b,
                 ifc.ALUResult, ifc.BrTaken);
        chk({tag, "_valid"}, {31'd0, ifc.out_valid}, 32'd1);
        chk({tag, "_result"}, ifc.ALUResult, exp_res);
        chk({tag, "_brtaken"}, {31'd0, ifc.BrTaken}, {31'd0, exp_br});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        ifc.flush     = 1'b0;
        ifc.out_ready = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0);

        // Reset state
        #3;
        chk("rst_out_valid", {31'd0, ifc.out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, ifc.in_ready}, 32'd1);
        chk("rst_result", ifc.ALUResult, 32'd0);
        chk("rst_regwrite", {31'd0, ifc.RegWrite_out}, 32'd0);
        chk("rst_rd", {27'd0, ifc.rd_out}, 32'd0);
        #9 reset = 1'b1;

        // First ADD: 1-cycle latency
        ifc.out_ready = 1'b1;
        drive(1'b1, 4'b0011, 32'd5, 32'd7, 1'b0, 1'b1, 5'd3);
        step();
        $display("txn add5_7 result=%h rd=%0d", ifc.ALUResult, ifc.rd_out);
        chk("add_valid", {31'd0, ifc.out_valid}, 32'd1);
        chk("add_result", ifc.ALUResult, 32'd12);
        chk("add_rd", {27'd0, ifc.rd_out}, 32'd3);
        chk("add_regwrite", {31'd0, ifc.RegWrite_out}, 32'd1);

        // Back-to-back ALU vectors
        send_check("sub",   4'b0100, 32'd0,          32'd1,          1'b0, 32'hFFFFFFFF, 1'b0);
        send_check("blt",   4'b0111, 32'hFFFFFFFF,   32'd1,          1'b1, 32'd1,        1'b1);
        send_check("bge",   4'b1000, 32'hFFFFFFFF,   32'd1,          1'b1, 32'd0,        1'b0);
        send_check("lui",   4'b1100, 32'hDEADBEEF,   32'h12345000,   1'b0, 32'h12345000, 1'b0);
        send_check("undef", 4'b1010, 32'd3,          32'd4,          1'b0, 32'd0,        1'b0);
        send_check("and",   4'b0000, 32'h0000F0F0,   32'h0000FF00,   1'b0, 32'h0000F000, 1'b0);
        send_check("or",    4'b0001, 32'h0000F0F0,   32'h0000FF00,   1'b0, 32'h0000FFF0, 1'b0);
        send_check("xor",   4'b0010, 32'h0000F0F0,   32'h0000FF00,   1'b0, 32'h00000FF0, 1'b0);
        send_check("beq",   4'b0101, 32'd5,          32'd5,          1'b1, 32'd1,        1'b1);
        send_check("bne",   4'b0110, 32'd5,          32'd5,          1'b1, 32'd0,        1'b0);
        send_check("addwr", 4'b0011, 32'hFFFFFFFF,   32'd2,          1'b0, 32'd1,        1'b0);
        send_check("ltpos", 4'b0111, 32'd1,          32'hFFFFFFFF,   1'b0, 32'd0,        1'b0);
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0);
        step();
        chk("drain_empty", {31'd0, ifc.out_valid}, 32'd0);

        // Back-pressure: A, B, C with out_ready low
        ifc.out_ready = 1'b0;
        drive(1'b1, 4'b0011, 32'd10, 32'd1, 1'b0, 1'b1, 5'd10);
        step();
        chk("bp_a_result", ifc.ALUResult, 32'd11);
        chk("bp_a_ready", {31'd0, ifc.in_ready}, 32'd1);
        drive(1'b1, 4'b0011, 32'd20, 32'd2, 1'b0, 1'b1, 5'd11);
        step();
        chk("bp_b_ready", {31'd0, ifc.in_ready}, 32'd0);
        chk("bp_b_hold", ifc.ALUResult, 32'd11);
        drive(1'b1, 4'b0011, 32'd30, 32'd3, 1'b0, 1'b1, 5'd12);
        step();
        chk("bp_c_ready", {31'd0, ifc.in_ready}, 32'd0);
        chk("bp_c_hold", ifc.ALUResult, 32'd11);
        step();
        chk("bp_stable_res", ifc.ALUResult, 32'd11);
        chk("bp_stable_rd", {27'd0, ifc.rd_out}, 32'd10);
        chk("bp_stable_valid", {31'd0, ifc.out_valid}, 32'd1);
        ifc.out_ready = 1'b1;
        step();
        $display("txn bp_out result=%h rd=%0d", ifc.ALUResult, ifc.rd_out);
        chk("bp_out_b", ifc.ALUResult, 32'd22);
        chk("bp_out_b_rd", {27'd0, ifc.rd_out}, 32'd11);
        chk("bp_ready_back", {31'd0, ifc.in_ready}, 32'd1);
        step();
        $display("txn bp_out result=%h rd=%0d", ifc.ALUResult, ifc.rd_out);
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0);
        chk("bp_out_c", ifc.ALUResult, 32'd33);
        chk("bp_out_c_valid", {31'd0, ifc.out_valid}, 32'd1);
        step();
        chk("bp_done", {31'd0, ifc.out_valid}, 32'd0);

        // Flush with stage full
        ifc.out_ready = 1'b0;
        drive(1'b1, 4'b0101, 32'd7, 32'd7, 1'b1, 1'b1, 5'd20);
        step();
        chk("fl_a_brtaken", {31'd0, ifc.BrTaken}, 32'd1);
        drive(1'b1, 4'b0011, 32'd1, 32'd2, 1'b0, 1'b1, 5'd21);
        step();
        chk("fl_full", {31'd0, ifc.in_ready}, 32'd0);
        drive(1'b1, 4'b0011, 32'd100, 32'd1, 1'b0, 1'b1, 5'd22);
        ifc.flush = 1'b1;
        step();
        $display("txn flush valid=%b ready=%b", ifc.out_valid, ifc.in_ready);
        ifc.flush = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0);
        chk("fl_valid", {31'd0, ifc.out_valid}, 32'd0);
        chk("fl_regwrite", {31'd0, ifc.RegWrite_out}, 32'd0);
        chk("fl_brtaken", {31'd0, ifc.BrTaken}, 32'd0);
        chk("fl_ready", {31'd0, ifc.in_ready}, 32'd1);
        ifc.out_ready = 1'b1;
        step();
        chk("fl_no_c", {31'd0, ifc.out_valid}, 32'd0);
        // Flush while empty discards the incoming item
        drive(1'b1, 4'b0011, 32'd4, 32'd4, 1'b0, 1'b1, 5'd23);
        ifc.flush = 1'b1;
        step();
        ifc.flush = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0);
        chk("fl_in_discard", {31'd0, ifc.out_valid}, 32'd0);

        // Asynchronous reset mid-stall with skid full
        ifc.out_ready = 1'b0;
        drive(1'b1, 4'b0011, 32'd40, 32'd1, 1'b0, 1'b1, 5'd24);
        step();
        drive(1'b1, 4'b0011, 32'd50, 32'd1, 1'b0, 1'b1, 5'd25);
        step();
        chk("rs_full", {31'd0, ifc.in_ready}, 32'd0);
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0);
        #1 reset = 1'b0;
        #1;
        chk("rs_valid", {31'd0, ifc.out_valid}, 32'd0);
        chk("rs_ready", {31'd0, ifc.in_ready}, 32'd1);
        chk("rs_result", ifc.ALUResult, 32'd0);
        reset = 1'b1;
        ifc.out_ready = 1'b1;
        drive(1'b1, 4'b0011, 32'd1, 32'd1, 1'b0, 1'b1, 5'd7);
        step();
        $display("txn post_reset_add result=%h rd=%0d", ifc.ALUResult, ifc.rd_out);
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0);
        chk("rs_add_valid", {31'd0, ifc.out_valid}, 32'd1);
        chk("rs_add_result", ifc.ALUResult, 32'd2);
        chk("rs_add_rd", {27'd0, ifc.rd_out}, 32'd7);
        step();
        chk("rs_end", {31'd0, ifc.out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
